// File: rtl/ibex_lsu_lite.sv
// Load/store unit with one outstanding aligned access, lane steering and load extension.
// Bus request is issued in the request cycle; the response is returned in the rvalid cycle.
// Backpressure: request held stable until grant, and lsu_req_i is ignored while busy.
// Optional macro IBEX_LSU_LITE_BUS_ERR_EN turns bus errors into load_err_o/store_err_o.
module ibex_lsu_lite #(
  parameter bit WritebackStage = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] adder_result_ex_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_req_done_o,
  output logic        lsu_resp_valid_o,
  output logic        rf_we_lsu_o,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        misaligned_err_o,
  output logic        busy_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  type_q, type_d;
  logic        sign_q, sign_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic        misaligned, issue, mis_pulse, resp_fin, bus_err;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, rdata_shift, load_ext;

`ifdef IBEX_LSU_LITE_BUS_ERR_EN
  assign bus_err = data_err_i;
`else
  logic unused_data_err;
  assign unused_data_err = data_err_i;
  assign bus_err         = 1'b0;
`endif

  // Decode the incoming request: byte enables, alignment and store lane steering.
  always_comb begin
    be_in      = 4'b1111;
    misaligned = |adder_result_ex_i[1:0];
    case (lsu_type_i)
      2'b01: begin
        be_in      = adder_result_ex_i[1] ? 4'b1100 : 4'b0011;
        misaligned = adder_result_ex_i[0];
      end
      2'b10: begin
        be_in      = 4'b0001 << adder_result_ex_i[1:0];
        misaligned = 1'b0;
      end
      default: ;
    endcase
    wdata_in = lsu_wdata_i << {adder_result_ex_i[1:0], 3'b000};
  end

  assign issue     = (state_q == IDLE) & lsu_req_i & ~misaligned;
  assign mis_pulse = (state_q == IDLE) & lsu_req_i & misaligned;
  assign resp_fin  = (state_q == WAIT_RVALID) & data_rvalid_i;

  // Next state and request capture; rvalid outside WAIT_RVALID is ignored.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    type_d  = type_q;
    sign_d  = sign_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          off_d   = adder_result_ex_i[1:0];
          type_d  = lsu_type_i;
          sign_d  = lsu_sign_ext_i;
          we_d    = lsu_we_i;
          addr_d  = {adder_result_ex_i[31:2], 2'b00};
          wdata_d = wdata_in;
          be_d    = be_in;
          state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT:    if (data_gnt_i) state_d = WAIT_RVALID;
      WAIT_RVALID: if (data_rvalid_i) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // State and captured request registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      type_q  <= 2'b00;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      type_q  <= type_d;
      sign_q  <= sign_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Bus fields: straight from the inputs in the issue cycle, from registers while waiting for grant.
  always_comb begin
    data_req_o   = 1'b0;
    data_addr_o  = 32'h0;
    data_we_o    = 1'b0;
    data_be_o    = 4'h0;
    data_wdata_o = 32'h0;
    if (issue) begin
      data_req_o   = 1'b1;
      data_addr_o  = {adder_result_ex_i[31:2], 2'b00};
      data_we_o    = lsu_we_i;
      data_be_o    = be_in;
      data_wdata_o = wdata_in;
    end else if (state_q == WAIT_GNT) begin
      data_req_o   = 1'b1;
      data_addr_o  = addr_q;
      data_we_o    = we_q;
      data_be_o    = be_q;
      data_wdata_o = wdata_q;
    end
  end

  // Load data: align the addressed lane down to bit 0, then zero/sign extend.
  always_comb begin
    rdata_shift = data_rdata_i >> {off_q, 3'b000};
    case (type_q)
      2'b10:   load_ext = {{24{sign_q & rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   load_ext = {{16{sign_q & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  assign lsu_resp_valid_o = resp_fin | mis_pulse;
  assign misaligned_err_o = mis_pulse;
  assign rf_we_lsu_o      = resp_fin & ~we_q & ~bus_err;
  assign rf_wdata_lsu_o   = rf_we_lsu_o ? load_ext : 32'h0;
  assign load_err_o       = resp_fin & bus_err & ~we_q;
  assign store_err_o      = resp_fin & bus_err & we_q;
  assign busy_o           = (state_q != IDLE);
  assign lsu_req_done_o   = WritebackStage ? ((data_req_o & data_gnt_i) | mis_pulse)
                                           : lsu_resp_valid_o;

  a_bus_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_req_o & ~data_gnt_i |=> data_req_o && $stable(data_addr_o) && $stable(data_we_o)
                                 && $stable(data_be_o) && $stable(data_wdata_o));
  a_single_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_req_o |-> state_q != WAIT_RVALID);
  a_no_rvalid_before_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    state_q == WAIT_GNT |-> !data_rvalid_i);
  a_rf_we_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rf_we_lsu_o |-> lsu_resp_valid_o);

endmodule

// File: doc/ibex_lsu_lite.md
Name: ibex_lsu_lite

Overview:
- Minimal load/store unit. Takes load/store requests from the ID/EX stage and drives the data-memory req/gnt/rvalid bus.
- Returns load data and a response strobe to the writeback stage: rf_we_lsu, rf_wdata_lsu, lsu_resp_valid.
- Supports one outstanding transaction, aligned accesses only.
- Handles byte/half/word lane steering and sign extension.

Parameters:
- WritebackStage, 1'b0: 1 = request completes towards ID/EX on grant, response arrives later in WB. 0 = request completes on rvalid.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- lsu_req_i  in  1  ID/EX requests a memory access this cycle
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_type_i  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- lsu_sign_ext_i  in  1  sign-extend load data
- adder_result_ex_i  in  32  byte address
- lsu_wdata_i  in  32  store data, LSB-aligned
- lsu_req_done_o  out  1  ID/EX may retire/advance the instruction
- lsu_resp_valid_o  out  1  one-cycle strobe: transaction finished
- rf_we_lsu_o  out  1  write load data to RF
- rf_wdata_lsu_o  out  32  extended load data
- load_err_o  out  1  load bus error
- store_err_o  out  1  store bus error
- misaligned_err_o  out  1  request rejected as misaligned
- busy_o  out  1  FSM not IDLE
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  bus response valid
- data_err_i  in  1  bus error, qualified by rvalid
- data_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- data_we_o  out  1  write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-steered store data
- data_rdata_i  in  32  read data

Behaviour:
- Reset: FSM = IDLE. All outputs 0. Latched offset/type/sign/we = 0.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- Misaligned = word with addr[1:0]!=0, or half with addr[0]=1.

IDLE:
- lsu_req_i & aligned: data_req_o=1 the same cycle. Bus fields are driven combinationally from the inputs. addr[1:0], type, sign_ext and we are latched.
- gnt the same cycle -> WAIT_RVALID; else -> WAIT_GNT.
- lsu_req_i & misaligned: no bus request. misaligned_err_o, lsu_resp_valid_o and lsu_req_done_o all pulse the same cycle. Stay in IDLE.
- rvalid in IDLE is ignored.

WAIT_GNT:
- data_req_o held at 1. addr/we/be/wdata come from registers and stay stable until gnt.
- gnt -> WAIT_RVALID.
- rvalid before gnt is ignored (protocol violation; assertion).

WAIT_RVALID:
- data_req_o=0.
- rvalid -> IDLE, with lsu_resp_valid_o=1 that cycle.
- No new request is issued in the rvalid cycle; the minimum issue spacing is one idle cycle.

General:
- lsu_req_i while busy_o=1 is ignored; ID/EX holds it.
- Byte enables:
  - word: 1111
  - half: offset 0 -> 0011, offset 2 -> 1100
  - byte: 0001 << offset
- data_wdata_o = lsu_wdata_i << (8*offset). Lanes outside data_be_o are don't-care.
- Load data: shift data_rdata_i right by 8*offset, take 8/16/32 bits, then zero- or sign-extend to 32.
- rf_we_lsu_o = lsu_resp_valid_o & ~we_q & ~error. rf_wdata_lsu_o is valid only with it and is 0 otherwise.
- lsu_req_done_o:
  - WritebackStage=1: asserted in the cycle data_req_o & data_gnt_i.
  - WritebackStage=0: asserted with lsu_resp_valid_o.
  - Misaligned requests assert it immediately in either configuration.
- busy_o = state != IDLE.
- Asynchronous reset mid-transaction: returns to IDLE immediately and data_req_o drops. A late rvalid for the abandoned transaction is ignored.
- Assertions:
  - bus fields stable while data_req_o & ~data_gnt_i
  - never two outstanding transactions
  - rf_we_lsu_o implies lsu_resp_valid_o

Optional Feature:
- Macro: IBEX_LSU_LITE_BUS_ERR_EN.
- Defined: data_err_i is sampled with rvalid. It pulses load_err_o or store_err_o (by we_q) alongside lsu_resp_valid_o and suppresses rf_we_lsu_o.
- Undefined: data_err_i is ignored. load_err_o and store_err_o are tied 0. data_err_i is routed to an unused signal.

Test Plan:
- Word load addr 0x1000, gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> data_be_o=1111, data_addr_o=0x1000; rf_we_lsu_o=1 with rf_wdata_lsu_o=0xDEADBEEF for exactly 1 cycle; busy_o low afterwards.
- Signed byte load addr 0x2003, rdata 0x80FF_FF00 -> be=1000, rf_wdata_lsu_o=0xFFFFFF80. Unsigned -> 0x00000080.
- Half store addr 0x3002, wdata 0x0000ABCD, gnt withheld 3 cycles -> data_req_o high for 4 cycles with be=1100 and data_wdata_o[31:16]=0xABCD stable; rf_we_lsu_o stays 0 on rvalid.
- Misaligned word load addr 0x4001 -> data_req_o stays 0; misaligned_err_o, lsu_resp_valid_o and lsu_req_done_o pulse 1 cycle.
- WritebackStage=1 vs 0, word load with gnt at cycle 0 and rvalid at cycle 2 -> lsu_req_done_o at cycle 0 vs cycle 2.
- Reset asserted in WAIT_RVALID, rvalid arrives after release -> no lsu_resp_valid_o or rf_we_lsu_o. With IBEX_LSU_LITE_BUS_ERR_EN, a load with rvalid & data_err_i -> load_err_o=1 and rf_we_lsu_o=0.
